gb_lcd_framer: RTL and testbench
================================

# gb_lcd_framer

Pixel-stream framer between the GameBoy PPU pixel output and the VGA-side LCD frame buffer, running on the GameBoy clock. It tracks line and frame position from PPU sync strobes, generates an explicit frame-buffer write address (y*160+x) for every pixel, and drops or flags malformed lines. When the LCD is disabled, it flushes the buffer to a fill colour. Its `LD`/`PX_VALID`/`WR_ADDR` outputs drive the frame buffer write port directly, replacing a free-running write counter so that a lost pixel cannot permanently skew the image.

## Interface
- `H_PIXELS`, 160, visible pixels per line
- `V_LINES`, 144, visible lines per frame
- `FB_DEPTH`, 23040, frame buffer entries (`H_PIXELS*V_LINES`)
- `ADDR_W`, 15, write address width
- `FILL_COLOR`, 2'b00, shade written during LCD-off flush

Ports:
- `GameBoy_clk` in 1: 2^22 Hz GameBoy clock, the block's only clock.
- `GameBoy_reset` in 1: asynchronous, active-high reset.
- `LCD_ON` in 1: LCDC bit 7, level.
- `PX_IN` in 2: PPU pixel shade.
- `PX_IN_VALID` in 1: `PX_IN` is valid this cycle.
- `HSYNC_IN` in 1: one-cycle strobe marking the end of a visible line.
- `VSYNC_IN` in 1: one-cycle strobe marking the start of a frame (line 0).
- `LD` out 2: shade to the frame buffer.
- `PX_VALID` out 1: write enable to the frame buffer.
- `WR_ADDR` out `ADDR_W`: frame buffer write address.
- `FRAME_DONE` out 1: one-cycle pulse when line `V_LINES-1` completes.
- `LINE_ERR` out 1: sticky flag for a line length other than `H_PIXELS`; cleared by reset only.

## Operation
- State machine states: SYNC, ACTIVE, FILL, BLANK. Reset enters SYNC.
- SYNC:
  - All pixels are ignored.
  - `VSYNC_IN` sets x=0, y=0 and moves to ACTIVE.
  - `LCD_ON`=0 moves to FILL.
- ACTIVE, per pixel (`PX_IN_VALID`=1):
  - If x<`H_PIXELS` and y<`V_LINES`: emit `LD`=`PX_IN`, `PX_VALID`=1, `WR_ADDR`=base+x, then x<=x+1.
  - Otherwise the pixel is dropped (`PX_VALID`=0).
  - base is the line start address, maintained incrementally (base+=`H_PIXELS` per line). No multiplier.
- ACTIVE, `HSYNC_IN`:
  - Length check: if the final pixel count ≠ `H_PIXELS`, set `LINE_ERR`. Count any pixel accepted in the same cycle.
  - Then x<=0.
  - If y<`V_LINES`: y<=y+1 and base+=`H_PIXELS`.
  - If y becomes `V_LINES`: pulse `FRAME_DONE`.
  - When y ≥ `V_LINES`, y saturates and base is unchanged.
- ACTIVE, `VSYNC_IN`: x<=0, y<=0, base<=0. A partial previous frame is abandoned; there is no `FRAME_DONE` for it and no error.
- ACTIVE, simultaneous events: a pixel in the same cycle as `HSYNC_IN` or `VSYNC_IN` is written at the pre-update position, then the counters update. If both syncs arrive together, `VSYNC_IN` wins for counter updates; the `HSYNC_IN` length check still runs.
- `LCD_ON` falling while in ACTIVE or SYNC moves to FILL on the next cycle, discarding the current position.
- FILL:
  - Writes `FILL_COLOR` to addresses 0..`FB_DEPTH`-1, one per clock. `PX_IN`, `PX_IN_VALID`, `HSYNC_IN`, `VSYNC_IN` are ignored.
  - After address `FB_DEPTH`-1, go to BLANK.
  - The fill always completes, even if `LCD_ON` rises mid-fill.
- BLANK: no writes. When `LCD_ON`=1, go to SYNC.
- Width rules:
  - x needs 8 bits and is compared with `H_PIXELS`.
  - y needs 8 bits.
  - base and the fill counter are `ADDR_W` bits; the maximum value is 23039 with no wrap.

## Timing
- All outputs are registered.
- Latency from `PX_IN_VALID`/`PX_IN` to `PX_VALID`/`LD`/`WR_ADDR` is exactly 1 cycle.
- `FRAME_DONE` asserts 1 cycle after the qualifying `HSYNC_IN`.
- Full-rate input (pixel every cycle) is supported with no stalls.
- FILL takes exactly `FB_DEPTH` cycles, from the cycle after entry to the last write.
- Reset values (asynchronous, immediate): `LD`=0, `PX_VALID`=0, `WR_ADDR`=0, `FRAME_DONE`=0, `LINE_ERR`=0, state=SYNC, x=y=base=fill counter=0.
- Reset asserted mid-frame or mid-fill aborts at once with no further writes. After release, the block waits for `VSYNC_IN`, or enters FILL if `LCD_ON`=0.
- `WR_ADDR` holds its last value when `PX_VALID`=0.

## Test plan
- **Full frame:**
  - Stimulus: `VSYNC_IN`, then 144 lines of 160 pixels, each line followed by `HSYNC_IN`; pixel value = (x+y)%4.
  - Required: exactly 23040 writes, `WR_ADDR`=y*160+x, `LD` matches, `FRAME_DONE` exactly once (1 cycle after the 144th `HSYNC_IN`), `LINE_ERR`=0.
- **Short and long lines:**
  - Stimulus: line 3 has 159 pixels; line 4 has 161 pixels.
  - Required: line 4 starts at address 640; the 161st pixel is not written; `LINE_ERR`=1 after the line 3 `HSYNC_IN`.
- **Mid-frame resync:**
  - Stimulus: `VSYNC_IN` at line 50, x=20.
  - Required: next pixel at `WR_ADDR`=0; no `FRAME_DONE` for the aborted frame.
- **Simultaneous pixel and sync:**
  - Stimulus: pixel with `HSYNC_IN` at x=159 of line 0.
  - Required: written at address 159; next pixel at 160; `LINE_ERR` stays 0.
- **LCD off:**
  - Stimulus: drop `LCD_ON` mid-frame; raise it again mid-fill.
  - Required: 23040 consecutive writes of 2'b00 at addresses 0..23039; BLANK, then SYNC; no pixel writes before the next `VSYNC_IN`.
- **Reset mid-operation:**
  - Stimulus: assert `GameBoy_reset` during line 10.
  - Required: `PX_VALID` falls immediately, all outputs are 0, and the first write after `VSYNC_IN` is at address 0.

Source files
------------

// File: rtl/gb_lcd_framer_if.sv
// Pixel/sync bus between the PPU side and the frame-buffer write port of gb_lcd_framer.
// The framer uses the slave modport; the pixel source and the frame buffer sit on the master side.
interface gb_lcd_framer_if #(
    parameter int ADDR_W = 15
);
    logic              LCD_ON;
    logic [1:0]        PX_IN;
    logic              PX_IN_VALID;
    logic              HSYNC_IN;
    logic              VSYNC_IN;
    logic [1:0]        LD;
    logic              PX_VALID;
    logic [ADDR_W-1:0] WR_ADDR;
    logic              FRAME_DONE;
    logic              LINE_ERR;

    modport master (
        output LCD_ON, PX_IN, PX_IN_VALID, HSYNC_IN, VSYNC_IN,
        input  LD, PX_VALID, WR_ADDR, FRAME_DONE, LINE_ERR
    );

    modport slave (
        input  LCD_ON, PX_IN, PX_IN_VALID, HSYNC_IN, VSYNC_IN,
        output LD, PX_VALID, WR_ADDR, FRAME_DONE, LINE_ERR
    );
endinterface

// File: rtl/gb_lcd_framer.sv
// Frames the PPU pixel stream into explicit frame-buffer writes (addr = y*160+x),
// drops/flags malformed lines, and flushes the buffer to a fill shade while the LCD is off.
//
// state  | meaning
// SYNC   | waiting for VSYNC_IN; pixels ignored
// ACTIVE | tracking x/y, writing visible pixels
// FILL   | writing FILL_COLOR to every buffer entry, one per clock
// BLANK  | fill done, waiting for LCD_ON
module gb_lcd_framer #(
    parameter int         H_PIXELS   = 160,
    parameter int         V_LINES    = 144,
    parameter int         FB_DEPTH   = 23040,
    parameter int         ADDR_W     = 15,
    parameter logic [1:0] FILL_COLOR = 2'b00
) (
    input  logic          GameBoy_clk,
    input  logic          GameBoy_reset,
    gb_lcd_framer_if.slave bus
);
    typedef enum logic [1:0] {SYNC, ACTIVE, FILL, BLANK} state_t;

    localparam logic [7:0]        X_MAX     = 8'(H_PIXELS);
    localparam logic [7:0]        Y_MAX     = 8'(V_LINES);
    localparam logic [7:0]        Y_LAST    = 8'(V_LINES - 1);
    localparam logic [ADDR_W-1:0] H_STEP    = ADDR_W'(H_PIXELS);
    localparam logic [ADDR_W-1:0] FILL_LAST = ADDR_W'(FB_DEPTH - 1);

    state_t            r_state, w_state_nxt;
    logic [7:0]        r_x, w_x_nxt;
    logic [7:0]        r_y, w_y_nxt;
    logic              r_x_ovf, w_x_ovf_nxt;
    logic [ADDR_W-1:0] r_base, w_base_nxt;
    logic [ADDR_W-1:0] r_fill_cnt, w_fill_cnt_nxt;
    logic [1:0]        r_ld, w_ld_nxt;
    logic              r_px_valid, w_px_valid_nxt;
    logic [ADDR_W-1:0] r_wr_addr, w_wr_addr_nxt;
    logic              r_frame_done, w_frame_done_nxt;
    logic              r_line_err, w_line_err_nxt;

    logic              w_accept;
    logic              w_drop;
    logic [7:0]        w_line_len;

    assign w_accept   = bus.PX_IN_VALID && (r_x < X_MAX) && (r_y < Y_MAX);
    // A pixel past the end of a visible line marks the line as too long.
    assign w_drop     = bus.PX_IN_VALID && !w_accept && (r_y < Y_MAX);
    assign w_line_len = r_x + {7'd0, w_accept};

    always_ff @(posedge GameBoy_clk or posedge GameBoy_reset) begin
        if (GameBoy_reset) begin
            r_state      <= SYNC;
            r_x          <= '0;
            r_y          <= '0;
            r_x_ovf      <= 1'b0;
            r_base       <= '0;
            r_fill_cnt   <= '0;
            r_ld         <= '0;
            r_px_valid   <= 1'b0;
            r_wr_addr    <= '0;
            r_frame_done <= 1'b0;
            r_line_err   <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_x          <= w_x_nxt;
            r_y          <= w_y_nxt;
            r_x_ovf      <= w_x_ovf_nxt;
            r_base       <= w_base_nxt;
            r_fill_cnt   <= w_fill_cnt_nxt;
            r_ld         <= w_ld_nxt;
            r_px_valid   <= w_px_valid_nxt;
            r_wr_addr    <= w_wr_addr_nxt;
            r_frame_done <= w_frame_done_nxt;
            r_line_err   <= w_line_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_x_nxt          = r_x;
        w_y_nxt          = r_y;
        w_x_ovf_nxt      = r_x_ovf;
        w_base_nxt       = r_base;
        w_fill_cnt_nxt   = '0;
        w_ld_nxt         = r_ld;
        w_px_valid_nxt   = 1'b0;
        w_wr_addr_nxt    = r_wr_addr;
        w_frame_done_nxt = 1'b0;
        w_line_err_nxt   = r_line_err;

        case (r_state)
            SYNC: begin
                if (!bus.LCD_ON) begin
                    w_state_nxt = FILL;
                    w_x_nxt     = '0;
                    w_y_nxt     = '0;
                    w_base_nxt  = '0;
                    w_x_ovf_nxt = 1'b0;
                end else if (bus.VSYNC_IN) begin
                    w_state_nxt = ACTIVE;
                    w_x_nxt     = '0;
                    w_y_nxt     = '0;
                    w_base_nxt  = '0;
                    w_x_ovf_nxt = 1'b0;
                end
            end

            ACTIVE: begin
                if (!bus.LCD_ON) begin
                    w_state_nxt = FILL;
                    w_x_nxt     = '0;
                    w_y_nxt     = '0;
                    w_base_nxt  = '0;
                    w_x_ovf_nxt = 1'b0;
                end else begin
                    if (w_accept) begin
                        w_ld_nxt       = bus.PX_IN;
                        w_px_valid_nxt = 1'b1;
                        w_wr_addr_nxt  = r_base + {{(ADDR_W-8){1'b0}}, r_x};
                        w_x_nxt        = r_x + 8'd1;
                    end
                    w_x_ovf_nxt = r_x_ovf | w_drop;

                    if (bus.HSYNC_IN) begin
                        // Lines after the last visible one are not measured.
                        if ((r_y < Y_MAX) && ((w_line_len != X_MAX) || r_x_ovf || w_drop))
                            w_line_err_nxt = 1'b1;
                        w_x_nxt     = '0;
                        w_x_ovf_nxt = 1'b0;
                        if (!bus.VSYNC_IN && (r_y < Y_MAX)) begin
                            w_y_nxt = r_y + 8'd1;
                            // base stops at the last line start so it never exceeds FB_DEPTH-1
                            if (r_y < Y_LAST)
                                w_base_nxt = r_base + H_STEP;
                            else
                                w_frame_done_nxt = 1'b1;
                        end
                    end

                    if (bus.VSYNC_IN) begin
                        w_x_nxt     = '0;
                        w_y_nxt     = '0;
                        w_base_nxt  = '0;
                        w_x_ovf_nxt = 1'b0;
                    end
                end
            end

            FILL: begin
                w_ld_nxt       = FILL_COLOR;
                w_px_valid_nxt = 1'b1;
                w_wr_addr_nxt  = r_fill_cnt;
                if (r_fill_cnt == FILL_LAST)
                    w_state_nxt = BLANK;
                else
                    w_fill_cnt_nxt = r_fill_cnt + 1'b1;
            end

            BLANK: begin
                if (bus.LCD_ON)
                    w_state_nxt = SYNC;
            end

            default: w_state_nxt = SYNC;
        endcase
    end

    assign bus.LD         = r_ld;
    assign bus.PX_VALID   = r_px_valid;
    assign bus.WR_ADDR    = r_wr_addr;
    assign bus.FRAME_DONE = r_frame_done;
    assign bus.LINE_ERR   = r_line_err;
endmodule

// File: tb/tb_gb_lcd_framer.sv
// Directed bench for gb_lcd_framer: full frame, resync, short/long lines, LCD-off flush, reset abort.
module tb_gb_lcd_framer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    gb_lcd_framer_if #(.ADDR_W(15)) bus ();

    gb_lcd_framer dut (
        .GameBoy_clk   (clk),
        .GameBoy_reset (rst),
        .bus           (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog expired obs=running exp=finished");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic cyc(input logic v, input logic [1:0] px, input logic hs, input logic vs);
        bus.PX_IN_VALID = v;
        bus.PX_IN       = px;
        bus.HSYNC_IN    = hs;
        bus.VSYNC_IN    = vs;
        @(posedge clk);
        #1;
    endtask

    task automatic send_line(input int y, input int n);
        for (int x = 0; x < n; x++) cyc(1'b1, 2'((x + y) % 4), 1'b0, 1'b0);
        cyc(1'b0, 2'd0, 1'b1, 1'b0);
    endtask

    initial begin
        int writes, miss, fdc, fdlast;
        bus.LCD_ON      = 1'b1;
        bus.PX_IN       = 2'd0;
        bus.PX_IN_VALID = 1'b0;
        bus.HSYNC_IN    = 1'b0;
        bus.VSYNC_IN    = 1'b0;
        #1;
        chk("rst_pv",   32'(bus.PX_VALID),   0);
        chk("rst_addr", 32'(bus.WR_ADDR),    0);
        chk("rst_ld",   32'(bus.LD),         0);
        chk("rst_fd",   32'(bus.FRAME_DONE), 0);
        chk("rst_err",  32'(bus.LINE_ERR),   0);
        @(posedge clk); #1;
        rst = 1'b0;

        // SYNC ignores pixels until VSYNC
        cyc(1'b1, 2'd3, 1'b0, 1'b0);
        cyc(1'b1, 2'd3, 1'b0, 1'b0);
        chk("sync_ignore", 32'(bus.PX_VALID), 0);

        // full frame
        writes = 0; miss = 0; fdc = 0; fdlast = 0;
        cyc(1'b0, 2'd0, 1'b0, 1'b1);
        for (int y = 0; y < 144; y++) begin
            for (int x = 0; x < 160; x++) begin
                cyc(1'b1, 2'((x + y) % 4), 1'b0, 1'b0);
                if (bus.PX_VALID === 1'b1) writes++;
                if (bus.PX_VALID !== 1'b1 || bus.WR_ADDR !== 15'(y * 160 + x) ||
                    bus.LD !== 2'((x + y) % 4)) miss++;
                if (bus.FRAME_DONE === 1'b1) fdc++;
            end
            cyc(1'b0, 2'd0, 1'b1, 1'b0);
            if (bus.FRAME_DONE === 1'b1) begin
                fdc++;
                if (y == 143) fdlast = 1;
            end
        end
        chk("ff_writes",  32'(writes), 23040);
        chk("ff_miss",    32'(miss),   0);
        chk("ff_fd_cnt",  32'(fdc),    1);
        chk("ff_fd_last", 32'(fdlast), 1);
        chk("ff_err",     32'(bus.LINE_ERR), 0);
        cyc(1'b0, 2'd0, 1'b0, 1'b0);
        chk("ff_fd_pulse", 32'(bus.FRAME_DONE), 0);
        cyc(1'b1, 2'd1, 1'b0, 1'b0);
        chk("ff_sat_drop", 32'(bus.PX_VALID), 0);
        chk("ff_addr_hold", 32'(bus.WR_ADDR), 23039);

        // pixel together with HSYNC at x=159 of line 0
        cyc(1'b0, 2'd0, 1'b0, 1'b1);
        for (int x = 0; x < 159; x++) cyc(1'b1, 2'd1, 1'b0, 1'b0);
        cyc(1'b1, 2'd3, 1'b1, 1'b0);
        chk("sim_pv",   32'(bus.PX_VALID), 1);
        chk("sim_addr", 32'(bus.WR_ADDR),  159);
        chk("sim_ld",   32'(bus.LD),       3);
        cyc(1'b1, 2'd2, 1'b0, 1'b0);
        chk("sim_next", 32'(bus.WR_ADDR),  160);
        chk("sim_err",  32'(bus.LINE_ERR), 0);

        // mid-frame resync at line 50, x=20 (pixel with VSYNC)
        cyc(1'b0, 2'd0, 1'b0, 1'b1);
        for (int y = 0; y < 50; y++) send_line(y, 160);
        for (int x = 0; x < 20; x++) cyc(1'b1, 2'd2, 1'b0, 1'b0);
        chk("rs_pre_addr", 32'(bus.WR_ADDR), 8019);
        cyc(1'b1, 2'd1, 1'b0, 1'b1);
        chk("rs_sim_addr", 32'(bus.WR_ADDR), 8020);
        cyc(1'b1, 2'd3, 1'b0, 1'b0);
        chk("rs_addr0", 32'(bus.WR_ADDR), 0);
        chk("rs_pv",    32'(bus.PX_VALID), 1);
        chk("rs_fd",    32'(bus.FRAME_DONE), 0);
        chk("rs_err",   32'(bus.LINE_ERR), 0);

        // short line 3, long line 4
        cyc(1'b0, 2'd0, 1'b0, 1'b1);
        for (int y = 0; y < 3; y++) send_line(y, 160);
        for (int x = 0; x < 159; x++) cyc(1'b1, 2'd1, 1'b0, 1'b0);
        chk("sl_err_pre", 32'(bus.LINE_ERR), 0);
        cyc(1'b0, 2'd0, 1'b1, 1'b0);
        chk("sl_err", 32'(bus.LINE_ERR), 1);
        cyc(1'b1, 2'd2, 1'b0, 1'b0);
        chk("ll_start", 32'(bus.WR_ADDR), 640);
        for (int x = 1; x < 160; x++) cyc(1'b1, 2'd2, 1'b0, 1'b0);
        chk("ll_last", 32'(bus.WR_ADDR), 799);
        cyc(1'b1, 2'd3, 1'b0, 1'b0);
        chk("ll_drop", 32'(bus.PX_VALID), 0);
        chk("ll_hold", 32'(bus.WR_ADDR), 799);
        cyc(1'b0, 2'd0, 1'b1, 1'b0);

        // LCD off mid-frame, back on mid-fill
        for (int x = 0; x < 5; x++) cyc(1'b1, 2'd1, 1'b0, 1'b0);
        bus.LCD_ON = 1'b0;
        cyc(1'b0, 2'd0, 1'b0, 1'b0);
        chk("off_first", 32'(bus.PX_VALID), 0);
        writes = 0; miss = 0;
        for (int i = 0; i < 23040; i++) begin
            if (i == 10000) bus.LCD_ON = 1'b1;
            cyc(1'b1, 2'd3, 1'(i % 7 == 0), 1'(i == 500));
            if (bus.PX_VALID === 1'b1) writes++;
            if (bus.PX_VALID !== 1'b1 || bus.WR_ADDR !== 15'(i) || bus.LD !== 2'b00) miss++;
        end
        chk("fill_writes", 32'(writes), 23040);
        chk("fill_miss",   32'(miss),   0);
        cyc(1'b1, 2'd3, 1'b0, 1'b0);
        chk("blank_pv", 32'(bus.PX_VALID), 0);
        writes = 0;
        for (int i = 0; i < 6; i++) begin
            cyc(1'b1, 2'd3, 1'b0, 1'b0);
            if (bus.PX_VALID === 1'b1) writes++;
        end
        chk("sync_nowrite", 32'(writes), 0);
        chk("fill_hold",    32'(bus.WR_ADDR), 23039);
        cyc(1'b0, 2'd0, 1'b0, 1'b1);
        cyc(1'b1, 2'd1, 1'b0, 1'b0);
        chk("resume_addr", 32'(bus.WR_ADDR), 0);
        chk("resume_ld",   32'(bus.LD), 1);

        // reset during line 10
        cyc(1'b0, 2'd0, 1'b0, 1'b1);
        for (int y = 0; y < 10; y++) send_line(y, 160);
        for (int x = 0; x < 5; x++) cyc(1'b1, 2'((x + 10) % 4), 1'b0, 1'b0);
        chk("pre_rst_addr", 32'(bus.WR_ADDR), 1604);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_pv",   32'(bus.PX_VALID),   0);
        chk("mid_rst_addr", 32'(bus.WR_ADDR),    0);
        chk("mid_rst_ld",   32'(bus.LD),         0);
        chk("mid_rst_fd",   32'(bus.FRAME_DONE), 0);
        chk("mid_rst_err",  32'(bus.LINE_ERR),   0);
        cyc(1'b1, 2'd3, 1'b0, 1'b0);
        cyc(1'b1, 2'd3, 1'b0, 1'b0);
        chk("in_rst_pv", 32'(bus.PX_VALID), 0);
        rst = 1'b0;
        cyc(1'b1, 2'd3, 1'b0, 1'b0);
        chk("post_rst_sync", 32'(bus.PX_VALID), 0);
        cyc(1'b0, 2'd0, 1'b0, 1'b1);
        cyc(1'b1, 2'd2, 1'b0, 1'b0);
        chk("post_rst_pv",   32'(bus.PX_VALID), 1);
        chk("post_rst_addr", 32'(bus.WR_ADDR),  0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
